mmio_input_port: RTL and testbench
==================================

// Module: mmio_input_port
// PURPOSE
//  Memory-mapped I/O responder on the CPU memory bus (mem_cmd/mem_addr), the input-side
//  counterpart to the HEX/LED display path. Synchronises and debounces KEY[3:0] and SW[9:0],
//  latches key-press events, serves CPU reads of switches/keys and CPU writes of LEDR[7:0].
//  Sits beside data RAM in the board top level; its read_data is muxed with RAM by read_valid.
// PARAMETERS
//  DATA_WIDTH       16        bus data width; reads zero-extend to this width
//  DEBOUNCE_CYCLES  500000    stable cycles before a key change is accepted (10 ms @ 50 MHz)
//  LED_ADDR         9'h100    read/write LED register
//  SW_ADDR          9'h140    read-only switch value
//  KEY_ADDR         9'h141    read-to-clear key event/level register
// PORTS
//  clk          in   1           system clock; single clock domain
//  reset        in   1           synchronous, active-high reset
//  KEY          in   4           raw push buttons, active-low, asynchronous
//  SW           in   10          raw slide switches, asynchronous
//  mem_cmd      in   2           bus command: MNONE / MREAD / MWRITE
//  mem_addr     in   9           bus address
//  write_data   in   DATA_WIDTH  bus write data
//  read_data    out  DATA_WIDTH  registered read data
//  read_valid   out  1           read_data belongs to this block (1-cycle pulse)
//  LEDR         out  8           LED register
//  key_level    out  4           debounced key state, 1 = pressed
//  key_press    out  4           1-cycle pulse on debounced released->pressed edge
// BEHAVIOUR
//  - Reset: read_data=0, read_valid=0, LEDR=0, key_level=0, key_press=0, events=0,
//    debounce counters=0, KEY sync flops=1 (released), SW sync flops=0.
//  - Reset mid-debounce discards any partial count; mid-read drops the pending response.
//  - Sync: 2-flop synchroniser per KEY and SW bit; key sample = ~KEY after sync.
//  - Debounce (per key): sample==key_level -> count<=0. Otherwise count++; when count reaches
//    DEBOUNCE_CYCLES-1, key_level<=sample and count<=0. Glitch shorter than
//    DEBOUNCE_CYCLES cycles never changes key_level. Total latency from raw KEY edge to
//    key_level = 2 sync cycles + DEBOUNCE_CYCLES cycles.
//  - key_press[i] asserted exactly the cycle after key_level[i] goes 0->1; none on release.
//  - events[3:0]: sticky, set by key_press. Read of KEY_ADDR clears them on the same edge the
//    read is accepted; if key_press[i] coincides with that read, events[i] stays 1 (set wins)
//    and the read returns the pre-edge value.
//  - Read: mem_cmd==MREAD at a decoded address -> next cycle read_valid=1 and read_data =
//      LED_ADDR: {0, LEDR}; SW_ADDR: {0, sw_sync[9:0]}; KEY_ADDR: {0, key_level, events}.
//    Undecoded address or non-read cmd -> next cycle read_valid=0, read_data=0.
//    Back-to-back reads produce back-to-back responses (1 per cycle, fixed 1-cycle latency).
//  - Write: mem_cmd==MWRITE at LED_ADDR -> LEDR<=write_data[7:0] on that edge.
//    Writes to SW_ADDR, KEY_ADDR or undecoded addresses are ignored (no event clear).
//  - mem_cmd value 2'b11 treated as MNONE.
// STRUCTURE
//  - Package risc_mmio_pkg: mem_cmd_t enum {MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10},
//    address constants LED_ADDR/SW_ADDR/KEY_ADDR (also used by the RAM decode).
//  - Sub-module key_debouncer (sync pair + counter + level + press pulse), one instance
//    per key via generate; counter width $clog2(DEBOUNCE_CYCLES).
//  - Top: SW sync, event register, address decode, read/write registers.
// TESTING (bench runs DEBOUNCE_CYCLES=4)
//  1. Reset held 3 cycles -> all outputs 0; read SW_ADDR with SW=10'h2A5 stable >2 cycles
//     -> next cycle read_valid=1, read_data=16'h02A5.
//  2. KEY[0] low for 10 cycles -> key_level[0]=1 after 6 cycles, one key_press[0] pulse;
//     read KEY_ADDR -> 16'h0011, second read -> 16'h0010.
//  3. KEY[2] low for 3 cycles then high -> key_level and key_press never assert.
//  4. Write 16'hBEEF to LED_ADDR -> LEDR=8'hEF next cycle; read LED_ADDR -> 16'h00EF;
//     write to SW_ADDR -> LEDR unchanged.
//  5. key_press[1] in same cycle as KEY_ADDR read -> returned events[1]=0, events[1]=1 after.
//  6. Read 9'h000 -> read_valid=0, read_data=0; reset asserted mid-debounce of KEY[3] ->
//     count cleared, key_level[3] stays 0 until a fresh full debounce period.

Source files
------------

// File: rtl/risc_mmio_pkg.sv
// -----------------------------------------------------------------------------
// risc_mmio_pkg
// Shared definitions for the CPU memory bus and its memory-mapped I/O space.
//   mem_cmd_t    : bus command encoding (MNONE / MREAD / MWRITE; 2'b11 acts as MNONE)
//   *_ADDR       : I/O register addresses, also used by the board-level RAM decode
//   mmio_sel_t   : which I/O register a bus address selects
//   decode_addr  : address -> register select
//   is_mmio_addr : true when an address belongs to the I/O block rather than RAM
// -----------------------------------------------------------------------------
package risc_mmio_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;
  localparam logic [8:0] KEY_ADDR = 9'h141;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_LED  = 2'b01,
    SEL_SW   = 2'b10,
    SEL_KEY  = 2'b11
  } mmio_sel_t;

  // Addresses are passed in so a parameterised instance can relocate its registers.
  function automatic mmio_sel_t decode_addr(
    input logic [8:0] addr,
    input logic [8:0] led_addr,
    input logic [8:0] sw_addr,
    input logic [8:0] key_addr
  );
    mmio_sel_t sel;
    if (addr == led_addr) begin
      sel = SEL_LED;
    end else if (addr == sw_addr) begin
      sel = SEL_SW;
    end else if (addr == key_addr) begin
      sel = SEL_KEY;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  // Used by the RAM side so it stays silent on I/O addresses.
  function automatic logic is_mmio_addr(input logic [8:0] addr);
    return decode_addr(addr, LED_ADDR, SW_ADDR, KEY_ADDR) != SEL_NONE;
  endfunction

endpackage

// File: rtl/mmio_input_port_if.sv
// -----------------------------------------------------------------------------
// mmio_input_port_if
// CPU memory-bus signals seen by an I/O responder.
//   mem_cmd    : command, driven by the CPU (MNONE / MREAD / MWRITE)
//   mem_addr   : 9-bit address, driven by the CPU
//   write_data : write payload, driven by the CPU
//   read_data  : registered read data, driven by the responder
//   read_valid : 1-cycle pulse, read_data belongs to this responder
// Modports: master (CPU side), slave (responder side).
// -----------------------------------------------------------------------------
interface mmio_input_port_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [1:0]            mem_cmd;
  logic [8:0]            mem_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  read_valid
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output read_valid
  );

endinterface

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// One push button: 2-flop synchroniser, stability counter, debounced level and
// a press pulse.
//   clk      in  : system clock
//   reset    in  : synchronous, active-high
//   i_key_n  in  : raw button, active-low, asynchronous
//   o_level  out : debounced state, 1 = pressed
//   o_press  out : 1-cycle pulse in the cycle after o_level rises
// A new button state is accepted only after it has differed from o_level for
// DEBOUNCE_CYCLES consecutive cycles; any return to the old state restarts
// the count.
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  // A one-cycle debounce still needs a 1-bit counter to exist.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_count;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic             w_sample;

  // Button is active-low; the sample is 1 while pressed.
  assign w_sample = ~r_sync;

  // Synchroniser pair; resets to "released" so no press is seen out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_key_n;
      r_sync <= r_meta;
    end
  end

  // Stability counter and debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
      r_level <= 1'b0;
    end else if (w_sample == r_level) begin
      r_count <= {CNT_W{1'b0}};
    end else if (r_count == CNT_LAST) begin
      r_level <= w_sample;
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Rising-edge detect on the debounced level; releases give no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/mmio_input_port.sv
// -----------------------------------------------------------------------------
// mmio_input_port
// Memory-mapped input responder on the CPU bus: synchronised switches,
// debounced keys with sticky press events, and a read/write LED register.
//   clk        in   : system clock, single domain
//   reset      in   : synchronous, active-high
//   KEY[3:0]   in   : raw push buttons, active-low, asynchronous
//   SW[9:0]    in   : raw slide switches, asynchronous
//   bus        if   : slave side of the CPU bus (mem_cmd, mem_addr, write_data,
//                     read_data, read_valid)
//   LEDR[7:0]  out  : LED register
//   key_level  out  : debounced key state, 1 = pressed
//   key_press  out  : 1-cycle pulse on debounced press
// Register map:
//   LED_ADDR  R/W  {0, LEDR}
//   SW_ADDR   R    {0, synchronised SW}
//   KEY_ADDR  R    {0, key_level, events}; the read clears events
// Reads answer one cycle after the command; read_valid stays low for
// undecoded addresses so the board top can mux RAM data on it.
// -----------------------------------------------------------------------------
module mmio_input_port #(
  parameter int         DATA_WIDTH      = 16,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [8:0] LED_ADDR        = risc_mmio_pkg::LED_ADDR,
  parameter logic [8:0] SW_ADDR         = risc_mmio_pkg::SW_ADDR,
  parameter logic [8:0] KEY_ADDR        = risc_mmio_pkg::KEY_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             KEY,
  input  logic [9:0]             SW,
  mmio_input_port_if.slave       bus,
  output logic [7:0]             LEDR,
  output logic [3:0]             key_level,
  output logic [3:0]             key_press
);

  import risc_mmio_pkg::mmio_sel_t;
  import risc_mmio_pkg::SEL_LED;
  import risc_mmio_pkg::SEL_SW;
  import risc_mmio_pkg::SEL_KEY;
  import risc_mmio_pkg::decode_addr;
  import risc_mmio_pkg::MREAD;
  import risc_mmio_pkg::MWRITE;

  logic [9:0]            r_sw_meta;
  logic [9:0]            r_sw_sync;
  logic [3:0]            r_events;
  logic [7:0]            r_ledr;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  logic [3:0]            w_key_level;
  logic [3:0]            w_key_press;
  mmio_sel_t             w_sel;
  logic                  w_is_read;
  logic                  w_is_write;
  logic                  w_key_read;
  logic                  w_read_hit;
  logic [DATA_WIDTH-1:0] w_read_mux;
  logic                  w_unused_wdata;

  // Only the LED byte of the write payload is stored.
  assign w_unused_wdata = ^bus.write_data;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debouncer (
        .clk     (clk),
        .reset   (reset),
        .i_key_n (KEY[g]),
        .o_level (w_key_level[g]),
        .o_press (w_key_press[g])
      );
    end
  endgenerate

  // Command/address decode and read-data selection for this cycle.
  always_comb begin
    w_sel      = decode_addr(bus.mem_addr, LED_ADDR, SW_ADDR, KEY_ADDR);
    w_is_read  = (bus.mem_cmd == MREAD);
    w_is_write = (bus.mem_cmd == MWRITE);
    w_key_read = w_is_read && (w_sel == SEL_KEY);
    w_read_hit = 1'b0;
    w_read_mux = {DATA_WIDTH{1'b0}};
    if (w_is_read) begin
      case (w_sel)
        SEL_LED: begin
          w_read_hit = 1'b1;
          w_read_mux = DATA_WIDTH'(r_ledr);
        end
        SEL_SW: begin
          w_read_hit = 1'b1;
          w_read_mux = DATA_WIDTH'(r_sw_sync);
        end
        SEL_KEY: begin
          w_read_hit = 1'b1;
          // Pre-edge events: a press landing on this edge is reported next read.
          w_read_mux = DATA_WIDTH'({w_key_level, r_events});
        end
        default: begin
          w_read_hit = 1'b0;
          w_read_mux = {DATA_WIDTH{1'b0}};
        end
      endcase
    end else begin
      w_read_hit = 1'b0;
      w_read_mux = {DATA_WIDTH{1'b0}};
    end
  end

  // Switch synchroniser pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= 10'h000;
      r_sw_sync <= 10'h000;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Sticky key events: a KEY_ADDR read clears them, a simultaneous press wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_events <= 4'h0;
    end else begin
      r_events <= (w_key_read ? 4'h0 : r_events) | w_key_press;
    end
  end

  // LED register; writes to any other address are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ledr <= 8'h00;
    end else if (w_is_write && (w_sel == SEL_LED)) begin
      r_ledr <= bus.write_data[7:0];
    end else begin
      r_ledr <= r_ledr;
    end
  end

  // Read response, fixed one-cycle latency; zero when nothing was decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_valid <= 1'b0;
      r_read_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_read_valid <= w_read_hit;
      r_read_data  <= w_read_mux;
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign LEDR           = r_ledr;
  assign key_level      = w_key_level;
  assign key_press      = w_key_press;

endmodule

// File: tb/tb_mmio_input_port.sv
// -----------------------------------------------------------------------------
// tb_mmio_input_port
// Directed scenarios plus randomised traffic for mmio_input_port, checked every
// cycle against a behavioural model that tracks delayed inputs, per-key
// "cycles since the sample disagreed with the level" run lengths, sticky
// events and the register map.
// -----------------------------------------------------------------------------
module tb_mmio_input_port;

  import risc_mmio_pkg::*;

  localparam int DW = 16;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [7:0] LEDR;
  logic [3:0] key_level;
  logic [3:0] key_press;

  mmio_input_port_if #(.DATA_WIDTH(DW)) bus_if ();

  mmio_input_port #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .KEY       (KEY),
    .SW        (SW),
    .bus       (bus_if),
    .LEDR      (LEDR),
    .key_level (key_level),
    .key_press (key_press)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [3:0]  m_key_d1, m_key_d2;
  logic [9:0]  m_sw_d1, m_sw_d2;
  int          m_run [4];
  logic [3:0]  m_level, m_level_prev, m_press, m_events;
  logic [7:0]  m_led;
  logic [15:0] m_rdata;
  logic        m_rvalid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [3:0]  sample, lvl_n, ev_n;
    logic [7:0]  led_n;
    logic [15:0] rd_n;
    logic        rv_n, is_rd, is_wr;
    if (reset) begin
      m_key_d1 = 4'hF; m_key_d2 = 4'hF;
      m_sw_d1 = 10'h000; m_sw_d2 = 10'h000;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_level = 4'h0; m_level_prev = 4'h0; m_press = 4'h0; m_events = 4'h0;
      m_led = 8'h00; m_rdata = 16'h0000; m_rvalid = 1'b0;
      return;
    end
    sample = ~m_key_d2;
    lvl_n  = m_level;
    for (int i = 0; i < 4; i++) begin
      if (sample[i] == m_level[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          lvl_n[i] = sample[i];
          m_run[i] = 0;
        end
      end
    end
    is_rd = (bus_if.mem_cmd == 2'b01);
    is_wr = (bus_if.mem_cmd == 2'b10);
    ev_n  = ((is_rd && bus_if.mem_addr == KEY_ADDR) ? 4'h0 : m_events) | m_press;
    rv_n  = 1'b0;
    rd_n  = 16'h0000;
    if (is_rd) begin
      if (bus_if.mem_addr == LED_ADDR) begin rv_n = 1'b1; rd_n = {8'h00, m_led}; end
      else if (bus_if.mem_addr == SW_ADDR) begin rv_n = 1'b1; rd_n = {6'h00, m_sw_d2}; end
      else if (bus_if.mem_addr == KEY_ADDR) begin rv_n = 1'b1; rd_n = {8'h00, m_level, m_events}; end
    end
    led_n = (is_wr && bus_if.mem_addr == LED_ADDR) ? bus_if.write_data[7:0] : m_led;
    m_press      = m_level & ~m_level_prev;
    m_level_prev = m_level;
    m_level      = lvl_n;
    m_events     = ev_n;
    m_led        = led_n;
    m_rdata      = rd_n;
    m_rvalid     = rv_n;
    m_key_d2     = m_key_d1;
    m_key_d1     = KEY;
    m_sw_d2      = m_sw_d1;
    m_sw_d1      = SW;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_val("read_data", bus_if.read_data, m_rdata);
    check_val("read_valid", bus_if.read_valid, m_rvalid);
    check_val("LEDR", LEDR, m_led);
    check_val("key_level", key_level, m_level);
    check_val("key_press", key_press, m_press);
  endtask

  task automatic set_bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus_if.mem_cmd    = cmd;
    bus_if.mem_addr   = addr;
    bus_if.write_data = wd;
  endtask

  initial begin
    bit         found;
    int         presses;
    logic [3:0] seen;
    int         hold [4];

    reset = 1'b1;
    KEY   = 4'hF;
    SW    = 10'h000;
    set_bus(MNONE, 9'h000, 16'h0000);

    // 1. Reset, then switch read
    repeat (3) tick();
    check_val("t1_rst_rvalid", bus_if.read_valid, 1'b0);
    check_val("t1_rst_rdata", bus_if.read_data, 16'h0000);
    check_val("t1_rst_ledr", LEDR, 8'h00);
    check_val("t1_rst_level", key_level, 4'h0);
    check_val("t1_rst_press", key_press, 4'h0);
    reset = 1'b0;
    SW = 10'h2A5;
    repeat (3) tick();
    set_bus(MREAD, SW_ADDR, 16'h0000);
    tick();
    set_bus(MNONE, 9'h000, 16'h0000);
    check_val("t1_sw_rvalid", bus_if.read_valid, 1'b1);
    check_val("t1_sw_rdata", bus_if.read_data, 16'h02A5);

    // 2. KEY[0] held 10 cycles, then two back-to-back KEY reads
    KEY = 4'hE;
    presses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (key_press[0]) presses++;
      if (k == 5) check_val("t2_level_c5", key_level[0], 1'b0);
      if (k == 6) check_val("t2_level_c6", key_level[0], 1'b1);
    end
    check_val("t2_press_count", presses, 1);
    set_bus(MREAD, KEY_ADDR, 16'h0000);
    tick();
    check_val("t2_read1", bus_if.read_data, 16'h0011);
    tick();
    check_val("t2_read2", bus_if.read_data, 16'h0010);
    check_val("t2_read2_valid", bus_if.read_valid, 1'b1);
    set_bus(MNONE, 9'h000, 16'h0000);
    KEY = 4'hF;
    repeat (10) tick();

    // 3. KEY[2] glitch shorter than the debounce period
    KEY = 4'hB;
    seen = 4'h0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) KEY = 4'hF;
      tick();
      seen = seen | key_level | key_press;
    end
    check_val("t3_glitch", seen[2], 1'b0);

    // 4. LED write/read, ignored write to SW_ADDR
    set_bus(MWRITE, LED_ADDR, 16'hBEEF);
    tick();
    set_bus(MNONE, 9'h000, 16'h0000);
    check_val("t4_ledr", LEDR, 8'hEF);
    set_bus(MREAD, LED_ADDR, 16'h0000);
    tick();
    check_val("t4_led_read", bus_if.read_data, 16'h00EF);
    set_bus(MWRITE, SW_ADDR, 16'h1234);
    tick();
    set_bus(MNONE, 9'h000, 16'h0000);
    tick();
    check_val("t4_ledr_kept", LEDR, 8'hEF);

    // 5. KEY read in the same cycle as key_press[1]
    KEY = 4'hD;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (key_press[1]) found = 1'b1;
    end
    check_val("t5_press_seen", found, 1'b1);
    set_bus(MREAD, KEY_ADDR, 16'h0000);
    tick();
    check_val("t5_read_coincide", bus_if.read_data, 16'h0020);
    tick();
    check_val("t5_read_after", bus_if.read_data, 16'h0022);
    set_bus(MNONE, 9'h000, 16'h0000);
    KEY = 4'hF;
    repeat (10) tick();

    // 6. Undecoded read, cmd 2'b11, reset mid-debounce
    set_bus(MREAD, 9'h000, 16'h0000);
    tick();
    check_val("t6_undec_rvalid", bus_if.read_valid, 1'b0);
    check_val("t6_undec_rdata", bus_if.read_data, 16'h0000);
    set_bus(2'b11, LED_ADDR, 16'h0055);
    tick();
    set_bus(MNONE, 9'h000, 16'h0000);
    tick();
    check_val("t6_cmd11_ledr", LEDR, 8'hEF);
    check_val("t6_cmd11_rvalid", bus_if.read_valid, 1'b0);
    KEY = 4'h7;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check_val("t6_level_c5", key_level[3], 1'b0);
      if (k == 6) check_val("t6_level_c6", key_level[3], 1'b1);
    end
    KEY = 4'hF;
    repeat (8) tick();

    // Randomised traffic
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 600; c++) begin
      logic [8:0] a;
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          KEY[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
        hold[i]--;
      end
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
      case ($urandom_range(0, 4))
        0:       a = LED_ADDR;
        1:       a = SW_ADDR;
        2, 3:    a = KEY_ADDR;
        default: a = 9'($urandom);
      endcase
      set_bus(2'($urandom_range(0, 3)), a, 16'($urandom));
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    set_bus(MNONE, 9'h000, 16'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
